// File: rtl/pattern_seq_if.sv
// Display-controller side of the pattern sequencer: frame/en/step requests in,
// stitch start masks and status out.
interface pattern_seq_if;
  logic        frame;
  logic        en;
  logic        step;
  logic [0:39] v_start;
  logic [0:29] h_start;
  logic        busy;
  logic        updated;

  modport master (
    output frame, en, step,
    input  v_start, h_start, busy, updated
  );

  modport slave (
    input  frame, en, step,
    output v_start, h_start, busy, updated
  );
endinterface

// File: rtl/pattern_seq.sv
// Stitch pattern sequencer: fills a 70-bit shadow from a Galois LFSR, then
// publishes it on the next frame pulse so the visible pattern never tears.
module pattern_seq #(
  parameter int unsigned FRAMES = 60,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  pattern_seq_if.slave  bus
);

  localparam logic [7:0]  LAST_FRAME = 8'(FRAMES - 1);
  localparam logic [6:0]  LAST_IDX   = 7'd69;
  localparam logic [15:0] TAPS       = 16'hB400;
  localparam logic [0:39] V_RESET    = 40'h614D3AD5ED;
  localparam logic [0:29] H_RESET    = 30'h2E90D0EA;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    READY
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  frame_cnt;
  logic [7:0]  frame_cnt_next;
  logic [6:0]  idx;
  logic [6:0]  idx_next;
  logic        gen_en;
  logic        load_out;
  logic [15:0] lfsr;
  logic [0:39] v_shadow;
  logic [0:29] h_shadow;
  logic [0:39] v_start_q;
  logic [0:29] h_start_q;
  logic        busy_q;
  logic        updated_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= 8'd0;
      idx       <= 7'd0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
      idx       <= idx_next;
    end
  end

  // A manual step and an auto trigger landing together still yield one pass,
  // since both simply select GEN; the counter wraps only on the auto path.
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    idx_next       = idx;
    gen_en         = 1'b0;
    load_out       = 1'b0;
    case (state)
      IDLE: begin
        idx_next = 7'd0;
        if (bus.frame && bus.en) begin
          if (frame_cnt == LAST_FRAME) begin
            frame_cnt_next = 8'd0;
            state_next     = GEN;
          end else begin
            frame_cnt_next = frame_cnt + 8'd1;
          end
        end
        if (bus.step) begin
          state_next = GEN;
        end
      end
      GEN: begin
        gen_en = 1'b1;
        if (idx == LAST_IDX) begin
          idx_next   = 7'd0;
          state_next = READY;
        end else begin
          idx_next = idx + 7'd1;
        end
      end
      READY: begin
        if (bus.frame) begin
          load_out   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      v_shadow  <= '0;
      h_shadow  <= '0;
      v_start_q <= V_RESET;
      h_start_q <= H_RESET;
      busy_q    <= 1'b0;
      updated_q <= 1'b0;
    end else begin
      busy_q    <= (state_next != IDLE);
      updated_q <= load_out;
      if (gen_en) begin
        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
        for (int k = 0; k < 40; k++) begin
          if (idx == 7'(k)) begin
            v_shadow[k] <= lfsr[0];
          end
        end
        for (int k = 0; k < 30; k++) begin
          if (idx == 7'(k + 40)) begin
            h_shadow[k] <= lfsr[0];
          end
        end
      end
      if (load_out) begin
        v_start_q <= v_shadow;
        h_start_q <= h_shadow;
      end
    end
  end

  assign bus.v_start = v_start_q;
  assign bus.h_start = h_start_q;
  assign bus.busy    = busy_q;
  assign bus.updated = updated_q;

endmodule

// File: tb/tb_pattern_seq.sv
// Self-checking bench for pattern_seq: directed scenarios plus random traffic,
// all compared against a transaction-level model of the update sequence.
module tb_pattern_seq;

  localparam int          FRAMES_TB = 3;
  localparam logic [15:0] SEED_TB   = 16'hACE1;
  localparam logic [0:39] V_RST     = 40'h614D3AD5ED;
  localparam logic [0:29] H_RST     = 30'h2E90D0EA;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pattern_seq_if bus ();

  pattern_seq #(
    .FRAMES (FRAMES_TB),
    .SEED   (SEED_TB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a whole update is computed at trigger time, then the
  // bench just counts down the fixed generation time and waits for a frame.
  logic [15:0] m_lfsr;
  int          m_cnt;
  int          m_gen_left;
  bit          m_ready;
  bit          m_busy;
  bit          m_upd;
  logic [0:39] m_v, m_vsh;
  logic [0:29] m_h, m_hsh;
  logic [0:39] ref_v;
  logic [0:29] ref_h;

  task automatic gen70(inout logic [15:0] l, output logic [0:39] v, output logic [0:29] h);
    bit b;
    for (int k = 0; k < 70; k++) begin
      b = l[0];
      l = (l >> 1) ^ (b ? 16'hB400 : 16'h0000);
      if (k < 40) v[k] = b;
      else        h[k - 40] = b;
    end
  endtask

  task automatic model_reset();
    m_lfsr     = SEED_TB;
    m_cnt      = 0;
    m_gen_left = 0;
    m_ready    = 0;
    m_busy     = 0;
    m_upd      = 0;
    m_v        = V_RST;
    m_h        = H_RST;
    m_vsh      = '0;
    m_hsh      = '0;
  endtask

  task automatic model_step(input bit f, input bit e, input bit s);
    bit trig;
    m_upd = 0;
    if (m_gen_left > 0) begin
      m_gen_left--;
      if (m_gen_left == 0) m_ready = 1;
    end else if (m_ready) begin
      if (f) begin
        m_v     = m_vsh;
        m_h     = m_hsh;
        m_upd   = 1;
        m_ready = 0;
      end
    end else begin
      trig = 0;
      if (f && e) begin
        if (m_cnt == FRAMES_TB - 1) begin
          m_cnt = 0;
          trig  = 1;
        end else begin
          m_cnt++;
        end
      end
      if (s) trig = 1;
      if (trig) begin
        gen70(m_lfsr, m_vsh, m_hsh);
        m_gen_left = 70;
      end
    end
    m_busy = (m_gen_left > 0) || m_ready;
  endtask

  task automatic compare_all(input string tag);
    n_checks++;
    if (bus.busy !== m_busy) begin
      n_fail++;
      $display("[TB] FAIL %s busy: got %0b expected %0b at %0t", tag, bus.busy, m_busy, $time);
    end
    n_checks++;
    if (bus.updated !== m_upd) begin
      n_fail++;
      $display("[TB] FAIL %s updated: got %0b expected %0b at %0t", tag, bus.updated, m_upd, $time);
    end
    n_checks++;
    if (bus.v_start !== m_v) begin
      n_fail++;
      $display("[TB] FAIL %s v_start: got %h expected %h at %0t", tag, bus.v_start, m_v, $time);
    end
    n_checks++;
    if (bus.h_start !== m_h) begin
      n_fail++;
      $display("[TB] FAIL %s h_start: got %h expected %h at %0t", tag, bus.h_start, m_h, $time);
    end
  endtask

  // Called at a falling edge: drive, clock, advance model, check at next falling edge.
  task automatic cycle(input bit f, input bit e, input bit s, input string tag);
    bus.frame = f;
    bus.en    = e;
    bus.step  = s;
    @(posedge clk);
    model_step(f, e, s);
    @(negedge clk);
    bus.frame = 1'b0;
    bus.step  = 1'b0;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n     = 1'b0;
    bus.frame = 1'b0;
    bus.step  = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    repeat (2) @(negedge clk);
    compare_all(tag);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.frame = 1'b0;
    bus.en    = 1'b0;
    bus.step  = 1'b0;
    rst_n     = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.updated !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_status: got busy=%0b updated=%0b expected 0/0", bus.busy, bus.updated);
    end
    n_checks++;
    if (bus.v_start !== V_RST || bus.h_start !== H_RST) begin
      n_fail++;
      $display("[TB] FAIL reset_pattern: got %h/%h expected %h/%h", bus.v_start, bus.h_start, V_RST, H_RST);
    end
    repeat (3) @(negedge clk);
    compare_all("reset_hold");
    rst_n = 1'b1;
    repeat (5) cycle(0, 0, 0, "reset_idle");
  endtask

  task automatic test_en_off();
    for (int fr = 0; fr < 10; fr++) begin
      cycle(1, 0, 0, "en_off");
      repeat (9) cycle(0, 0, 0, "en_off");
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.v_start !== V_RST || bus.h_start !== H_RST) begin
      n_fail++;
      $display("[TB] FAIL en_off_hold: got busy=%0b v=%h h=%h expected 0 %h %h",
               bus.busy, bus.v_start, bus.h_start, V_RST, H_RST);
    end
  endtask

  task automatic test_manual_step();
    cycle(0, 0, 1, "step");
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL step_busy_rise: got %0b expected 1", bus.busy);
    end
    repeat (69) cycle(0, 0, 0, "step_gen");
    // This frame lands on the last generation edge and must be ignored.
    cycle(1, 0, 0, "step_last_gen_frame");
    n_checks++;
    if (bus.updated !== 1'b0 || bus.v_start !== V_RST || bus.busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL step_frame_in_gen: got upd=%0b busy=%0b v=%h expected 0 1 %h",
               bus.updated, bus.busy, bus.v_start, V_RST);
    end
    repeat (3) cycle(0, 0, 0, "step_ready");
    cycle(1, 0, 0, "step_publish");
    n_checks++;
    if (bus.updated !== 1'b1 || bus.v_start[0] !== 1'b1 || bus.v_start[1] !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL step_publish: got upd=%0b v0=%0b v1=%0b busy=%0b expected 1 1 0 0",
               bus.updated, bus.v_start[0], bus.v_start[1], bus.busy);
    end
    ref_v = m_v;
    ref_h = m_h;
    cycle(0, 0, 0, "step_after");
  endtask

  task automatic test_auto();
    bit exp_busy, exp_upd;
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 1, 0, "auto_frame");
      exp_busy = (k == 3) || (k == 7);
      exp_upd  = (k == 4) || (k == 8);
      n_checks++;
      if (bus.busy !== exp_busy || bus.updated !== exp_upd) begin
        n_fail++;
        $display("[TB] FAIL auto_frame%0d: got busy=%0b upd=%0b expected %0b %0b",
                 k, bus.busy, bus.updated, exp_busy, exp_upd);
      end
      repeat (99) cycle(0, 1, 0, "auto_gap");
    end
  endtask

  task automatic test_ignore_triggers();
    int upd_count;
    upd_count = 0;
    cycle(0, 0, 1, "ign_step");
    for (int c = 1; c < 160; c++) begin
      cycle((c == 30) || (c == 90), 1'b0, (c == 10) || (c == 40) || (c == 75) || (c == 80), "ign");
      if (bus.updated === 1'b1) upd_count++;
      if (c > 90) begin
        n_checks++;
        if (bus.busy !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL ign_no_second_gen: got busy=%0b expected 0 at c=%0d", bus.busy, c);
        end
      end
    end
    n_checks++;
    if (upd_count != 1) begin
      n_fail++;
      $display("[TB] FAIL ign_update_count: got %0d expected 1", upd_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] l;
    logic [0:39] v1, v2;
    logic [0:29] h1, h2;
    l = m_lfsr;
    gen70(l, v1, h1);
    gen70(l, v2, h2);
    cycle(0, 0, 1, "b2b_step1");
    repeat (72) cycle(0, 0, 0, "b2b_gen1");
    cycle(1, 0, 0, "b2b_pub1");
    n_checks++;
    if (bus.v_start !== v1 || bus.h_start !== h1) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: got %h/%h expected %h/%h", bus.v_start, bus.h_start, v1, h1);
    end
    cycle(0, 0, 1, "b2b_step2");
    repeat (70) cycle(0, 0, 0, "b2b_gen2");
    cycle(1, 0, 0, "b2b_pub2");
    n_checks++;
    if (bus.v_start !== v2 || bus.h_start !== h2 || bus.updated !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got %h/%h upd=%0b expected %h/%h 1",
               bus.v_start, bus.h_start, bus.updated, v2, h2);
    end
  endtask

  task automatic test_mid_gen_reset();
    cycle(0, 0, 1, "mid_step");
    repeat (35) cycle(0, 0, 0, "mid_gen");
    do_reset("mid_reset");
    n_checks++;
    if (bus.busy !== 1'b0 || bus.v_start !== V_RST || bus.h_start !== H_RST) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_values: got busy=%0b v=%h h=%h", bus.busy, bus.v_start, bus.h_start);
    end
    cycle(0, 0, 0, "mid_release");
    cycle(0, 0, 1, "mid_restep");
    repeat (72) cycle(0, 0, 0, "mid_regen");
    cycle(1, 0, 0, "mid_publish");
    n_checks++;
    if (bus.v_start !== ref_v || bus.h_start !== ref_h) begin
      n_fail++;
      $display("[TB] FAIL mid_reproduce: got %h/%h expected %h/%h", bus.v_start, bus.h_start, ref_v, ref_h);
    end
  endtask

  task automatic test_random();
    bit e;
    e = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ((c % 250) == 0) e = $urandom_range(0, 3) != 0;
      cycle($urandom_range(0, 19) == 0, e, $urandom_range(0, 149) == 0, "random");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_en_off();
    test_manual_step();
    test_auto();
    test_ignore_triggers();
    test_back_to_back();
    test_mid_gen_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_seq.md
PATTERN_SEQ -- requirements
Module: pattern_seq

Interface
REQ-001 Parameter: FRAMES, default 60, number of enabled frame pulses between automatic pattern updates (range 1..255).
REQ-002 Parameter: SEED, default 16'hACE1, LFSR reset value (SHALL be non-zero).
REQ-003 Port: clk  input  1  system/pixel clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: frame  input  1  frame-start pulse from the display controller, one cycle per frame.
REQ-006 Port: en  input  1  automatic animation enable (level).
REQ-007 Port: step  input  1  manual update request (single-cycle pulse).
REQ-008 Port: v_start  output  40  vertical stitch start bits, indexed [0:39], index 0 = leftmost column.
REQ-009 Port: h_start  output  30  horizontal stitch start bits, indexed [0:29], index 0 = top row.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: updated  output  1  one-cycle pulse in the cycle v_start/h_start first show new values.

Function
REQ-012 Internal 16-bit Galois LFSR: per advance, out = lfsr[0]; lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
REQ-013 LFSR SHALL advance only in GEN, once per cycle, and SHALL NOT be re-seeded between updates.
REQ-014 FSM states IDLE, GEN, READY; all outputs registered.
REQ-015 IDLE: 8-bit frame counter increments on frame when en=1; holds when en=0.
REQ-016 IDLE: frame with en=1 and counter==FRAMES-1 -> counter <= 0, state <= GEN (auto trigger).
REQ-017 IDLE: step=1 -> state <= GEN; counter SHALL NOT change unless REQ-016 fires the same cycle.
REQ-018 Simultaneous step and auto trigger SHALL produce exactly one GEN pass.
REQ-019 GEN: 7-bit index counter i runs 0..69; each cycle LFSR out bit written to shadow bit i (bits 0..39 -> v shadow [0:39], 40..69 -> h shadow [0:29]).
REQ-020 GEN lasts exactly 70 cycles; after writing i=69, state <= READY.
REQ-021 READY: on frame=1, v_start/h_start <= shadow on that edge, updated=1 for that one cycle, state <= IDLE.
REQ-022 v_start/h_start SHALL change only per REQ-021 (never mid-frame, never in GEN).
REQ-023 step and frame-counter triggers in GEN or READY SHALL be ignored (no queueing); frame counter holds in GEN and READY.
REQ-024 Latency: trigger sampled at edge N -> busy=1 from N+1, GEN cycles N+1..N+70, READY from N+71.
REQ-025 en deassertion during GEN/READY SHALL NOT abort the pending update.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, frame counter 0, index 0, LFSR = SEED, shadow 0, busy 0, updated 0.
REQ-027 Reset values: v_start = 40'h614D3AD5ED, h_start = 30'h2E90D0EA (hex written with index 0 as MSB).
REQ-028 Reset asserted mid-GEN or in READY SHALL discard the shadow; outputs return to REQ-027 values.

Verification
REQ-029 Reset, then step pulse at cycle 0 -> busy=1 at cycle 1, READY at cycle 71; next frame -> updated=1, v_start[0]=1, v_start[1]=0 (SEED=16'hACE1).
REQ-030 FRAMES=3, en=1, frame every 100 cycles -> GEN entered after 3rd frame; v/h change at 4th frame with updated pulse; counter restarts at 0.
REQ-031 en=0, 10 frames, no step -> busy stays 0, outputs hold reset values.
REQ-032 step pulses during GEN and READY -> exactly one update; busy drops after update; no second GEN.
REQ-033 rst_n low at GEN i=35 -> outputs immediately at reset values, busy=0; subsequent step reproduces REQ-029 bit pattern.
REQ-034 Two consecutive step-driven updates -> second shadow equals next 70 LFSR bits of a software Galois model (0xB400) with no re-seed.
